pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage integer pipeline. It drives the enable and flush/bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards: load-use data hazards, taken-branch redirects, and multi-cycle data-memory accesses through a req/ack handshake with timeout.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/load_use_detect.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    localparam ctrl_t      c_nop_ctrl = '0;
    localparam logic [4:0] REG_X0     = 5'd0;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module : load_use_detect
// Brief  : Flags an ID-stage read of the register a load in EX will write.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_memRead,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = id_uses_rs1 && (id_rs1 == ex_rd);
    assign w_hit_rs2 = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hard-wired to zero, so a load targeting it never creates a dependency
    assign hazard    = ex_memRead && (ex_rd != REG_X0) && (w_hit_rs1 || w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Stall/flush sequencer for the 5-stage pipeline (load-use, branch,
//          multi-cycle data memory with timeout). Optional PERF_CNT_EN adds
//          a saturating stall-cycle counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_memRead,
    input  logic [4:0] ex_rd,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       dmem_rdata_le,
    output logic       dmem_err,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       memwb_bubble
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    localparam logic [7:0] c_timer_last = 8'(TIMEOUT_CYC - 1);

    state_t     r_state;
    logic       r_dmem_req;
    logic       r_dmem_err;
    logic [7:0] r_timer;
    logic       w_load_use;
    logic       w_freeze;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_memRead  (ex_memRead),
        .ex_rd       (ex_rd),
        .hazard      (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_dmem_req <= 1'b0;
            r_dmem_err <= 1'b0;
            r_timer    <= 8'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_req) begin
                        r_state    <= WAIT;
                        r_dmem_req <= 1'b1;
                        r_timer    <= 8'd0;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        r_state    <= DONE;
                        r_dmem_req <= 1'b0;
                    end else if (r_timer == c_timer_last) begin
                        r_state    <= DONE;
                        r_dmem_req <= 1'b0;
                        r_dmem_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                DONE:    r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // DONE deliberately ignores mem_req: EX/MEM still holds the finished access
    assign w_freeze = (r_state == WAIT) || ((r_state == RUN) && mem_req);

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_en = 1'b1;
        end else if (w_freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign dmem_req      = r_dmem_req;
    assign dmem_err      = r_dmem_err;
    assign dmem_rdata_le = (r_state == WAIT) && dmem_ack;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!pc_en && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    if (CNT_W > 0) begin : g_no_stall_cnt
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed vector bench for pipe_hazard_ctrl (TIMEOUT_CYC = 4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       mreq;
        logic       ack;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic [10:0] exp;
    } vec_t;

    // {pc,ifid,idex,exmem,memwb, ifid_flush,idex_flush,bubble}
    localparam logic [7:0] c_norm = 8'b11111_000;
    localparam logic [7:0] c_frz  = 8'b00000_001;
    localparam logic [7:0] c_lu   = 8'b00111_010;
    localparam logic [7:0] c_br   = 8'b11111_110;

    localparam in_t c_idle = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    localparam in_t c_lu5  = '{5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_memRead, ex_branch_taken, mem_req, dmem_ack;
    logic       dmem_req, dmem_rdata_le, dmem_err;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, memwb_bubble;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stalls = 0;

    pipe_hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_memRead      (ex_memRead),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ack        (dmem_ack),
        .dmem_req        (dmem_req),
        .dmem_rdata_le   (dmem_rdata_le),
        .dmem_err        (dmem_err),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_bubble    (memwb_bubble)
`ifdef PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, check mid-cycle, then advance past the edge.
    task automatic step(input in_t i, input logic [10:0] exp, input string nm);
        logic [10:0] got;
        {id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memRead, ex_rd,
         ex_branch_taken, mem_req, dmem_ack} = i;
        #4;
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               memwb_bubble, dmem_req, dmem_rdata_le, dmem_err};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
`ifdef PERF_CNT_EN
        n_tests++;
        if (stall_cycles !== 32'(exp_stalls)) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_cycles, exp_stalls);
        end
`endif
        if (rst_n && !exp[10]) exp_stalls++;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];
    in_t  t;

    initial begin
        vecs[0] = '{c_idle, {c_norm, 3'b000}};
        vecs[1] = '{c_lu5,  {c_lu,   3'b000}};
        vecs[2] = '{c_idle, {c_norm, 3'b000}};
        vecs[3] = '{'{5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0}, {c_norm, 3'b000}};
        vecs[4] = '{'{5'd7, 5'd1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0}, {c_lu,   3'b000}};
        vecs[5] = '{'{5'd7, 5'd1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0}, {c_norm, 3'b000}};
        vecs[6] = '{'{5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0}, {c_norm, 3'b000}};
        vecs[7] = '{'{5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0}, {c_br,   3'b000}};
        vecs[8] = '{'{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0}, {c_br,   3'b000}};
        vecs[9] = '{'{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1}, {c_norm, 3'b000}};

        rst_n = 1'b0;
        {id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memRead, ex_rd,
         ex_branch_taken, mem_req, dmem_ack} = c_idle;
        repeat (2) @(posedge clk);
        #1;
        step(c_idle, {c_norm, 3'b000}, "reset_state");
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            step(vecs[k].in, vecs[k].exp, $sformatf("vec%0d", k));
        end

        // Memory access acked on the third WAIT cycle; hazards ignored while frozen.
        t = c_lu5; t.br = 1'b1; t.mreq = 1'b1;
        step(t, {c_frz, 3'b000}, "acc_detect");
        t = c_idle; t.mreq = 1'b1;
        step(t, {c_frz, 3'b100}, "acc_wait1");
        step(t, {c_frz, 3'b100}, "acc_wait2");
        t.ack = 1'b1;
        step(t, {c_frz, 3'b110}, "acc_wait3_ack");
        t.ack = 1'b0;
        step(t, {c_norm, 3'b000}, "acc_done");
        t = c_idle; t.br = 1'b1;
        step(t, {c_br, 3'b000}, "acc_run_after");

        // No ack: four WAIT cycles, then sticky error.
        t = c_idle; t.mreq = 1'b1;
        step(t, {c_frz, 3'b000}, "to_detect");
        for (int k = 0; k < 4; k++) begin
            step(t, {c_frz, 3'b100}, $sformatf("to_wait%0d", k));
        end
        t = c_idle; t.br = 1'b1; t.mreq = 1'b1; t.ack = 1'b1;
        step(t, {c_br, 3'b001}, "to_done_branch");
        step(c_idle, {c_norm, 3'b001}, "to_run_sticky");
        step(c_lu5,  {c_lu,   3'b001}, "to_run_loaduse");

        // Reset arriving mid-WAIT.
        t = c_idle; t.mreq = 1'b1;
        step(t, {c_frz, 3'b001}, "rst_detect");
        step(t, {c_frz, 3'b101}, "rst_wait1");
        rst_n = 1'b0;
        step(t, {c_norm, 3'b101}, "rst_forced");
        rst_n = 1'b1;
        exp_stalls = 0;
        step(c_idle, {c_norm, 3'b000}, "rst_after");
        step(c_lu5,  {c_lu,   3'b000}, "rst_loaduse");
        step(c_idle, {c_norm, 3'b000}, "rst_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
